acc_ctrl: RTL and testbench

ACC_CTRL -- requirements
Module: acc_ctrl

---
 rtl/acc_pkg.sv | 38 +++
 rtl/acc_ctrl_if.sv | 21 ++
 rtl/acc_bus_decode.sv | 22 ++
 rtl/acc_ctrl.sv | 139 +++++++++++++
 tb/tb_acc_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// Shared types and constants for the accelerator control block: FSM states, regions, register map.
// No logic; no latency or backpressure of its own.
package acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RGN_REG = 2'd0,
    RGN_A   = 2'd1,
    RGN_B   = 2'd2,
    RGN_C   = 2'd3
  } region_t;

  localparam logic [11:0] BASE_A   = 12'd1024;
  localparam logic [11:0] BASE_B   = 12'd2048;
  localparam logic [11:0] BASE_C   = 12'd3072;
  localparam logic [11:0] NUM_REGS = 12'd4;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CYCLES  = 2'd2;
  localparam logic [1:0] REG_TIMEOUT = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLR    = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TMO_ERR = 2;
  localparam int STAT_ACC_ERR = 3;

endpackage

// File: rtl/acc_ctrl_if.sv
// Host data bus: request/grant with a single response beat (rvalid) one cycle after each grant.
// Grant is unconditional, so the bus never backpressures.
interface acc_ctrl_if;
  logic        data_req_i;
  logic        data_we_i;
  logic [11:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;

  modport slave (
    input  data_req_i, data_we_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o
  );

  modport master (
    output data_req_i, data_we_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o
  );
endinterface

// File: rtl/acc_bus_decode.sv
// Splits a 12-bit bus address into region, register index and reserved flag.
// Purely combinational: zero latency, no backpressure.
module acc_bus_decode
  import acc_pkg::*;
(
  input  logic [11:0] i_addr,
  output region_t     o_region,
  output logic [1:0]  o_reg_idx,
  output logic        o_reserved
);

  always_comb begin
    if (i_addr >= BASE_C)      o_region = RGN_C;
    else if (i_addr >= BASE_B) o_region = RGN_B;
    else if (i_addr >= BASE_A) o_region = RGN_A;
    else                       o_region = RGN_REG;
  end

  assign o_reg_idx  = i_addr[1:0];
  assign o_reserved = (o_region == RGN_REG) && (i_addr >= NUM_REGS);

endmodule

// File: rtl/acc_ctrl.sv
// Accelerator control: register file, A/B buffer write path, C readback and run/timeout FSM.
// Buffer strobes same cycle, read data one cycle after grant; grant is zero-wait, no backpressure.
module acc_ctrl
  import acc_pkg::*;
#(
  parameter int N_ELEM = 1024,
  parameter int EW     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  acc_ctrl_if.slave                 bus,
  output logic                      buf_we_o,
  output logic                      buf_sel_o,
  output logic [$clog2(N_ELEM)-1:0] buf_addr_o,
  output logic [EW-1:0]             buf_wdata_o,
  output logic [$clog2(N_ELEM)-1:0] c_raddr_o,
  input  logic [EW-1:0]             c_rdata_i,
  output logic                      acc_start_o,
  input  logic                      acc_done_i,
  output logic                      irq_o
);

  localparam int AW = $clog2(N_ELEM);

  region_t     w_region;
  logic [1:0]  w_reg_idx;
  logic        w_reserved;

  acc_bus_decode u_dec (
    .i_addr     (bus.data_addr_i),
    .o_region   (w_region),
    .o_reg_idx  (w_reg_idx),
    .o_reserved (w_reserved)
  );

  state_t      r_state;
  logic        r_irq_en;
  logic        r_acc_err;
  logic        r_start;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [31:0] r_cycles;
  logic [31:0] r_timeout;

  logic        w_req, w_wr, w_rd, w_run;
  logic        w_reg_wr, w_ab_wr, w_c_rd, w_buf_we;
  logic        w_ctrl_wr, w_start_wr, w_clr_wr, w_stat_clr;
  logic [31:0] w_cyc_nxt, w_status, w_rd_dat;

  // Bus-facing combinational paths are gated by reset so outputs sit at 0 while it is held.
  assign w_req      = bus.data_req_i & rst_n;
  assign w_wr       = w_req & bus.data_we_i;
  assign w_rd       = w_req & ~bus.data_we_i;
  assign w_run      = (r_state == ST_RUN);
  assign w_reg_wr   = w_wr & (w_region == RGN_REG) & ~w_reserved;
  assign w_ab_wr    = w_wr & ((w_region == RGN_A) | (w_region == RGN_B));
  assign w_c_rd     = w_rd & (w_region == RGN_C);
  assign w_buf_we   = w_ab_wr & ~w_run;
  assign w_ctrl_wr  = w_reg_wr & (w_reg_idx == REG_CTRL);
  assign w_start_wr = w_ctrl_wr & bus.data_wdata_i[CTRL_START];
  assign w_clr_wr   = w_ctrl_wr & bus.data_wdata_i[CTRL_CLR];
  assign w_stat_clr = w_reg_wr & (w_reg_idx == REG_STATUS) & bus.data_wdata_i[STAT_ACC_ERR];
  assign w_cyc_nxt  = (&r_cycles) ? r_cycles : r_cycles + 32'd1;

  always_comb begin
    w_status               = '0;
    w_status[STAT_BUSY]    = w_run;
    w_status[STAT_DONE]    = (r_state == ST_DONE);
    w_status[STAT_TMO_ERR] = (r_state == ST_ERR);
    w_status[STAT_ACC_ERR] = r_acc_err;
  end

  always_comb begin
    w_rd_dat = '0;
    if (w_region == RGN_C) begin
      if (!w_run) w_rd_dat = {{(32-EW){1'b0}}, c_rdata_i};
    end else if (w_region == RGN_REG && !w_reserved) begin
      case (w_reg_idx)
        REG_CTRL:    w_rd_dat[CTRL_IRQ_EN] = r_irq_en;
        REG_STATUS:  w_rd_dat = w_status;
        REG_CYCLES:  w_rd_dat = r_cycles;
        REG_TIMEOUT: w_rd_dat = r_timeout;
        default:     w_rd_dat = '0;
      endcase
    end
  end

  assign bus.data_gnt_o    = w_req;
  assign bus.data_rvalid_o = r_rvalid;
  assign bus.data_rdata_o  = r_rdata;
  assign buf_we_o          = w_buf_we;
  assign buf_sel_o         = w_buf_we & bus.data_addr_i[11];
  assign buf_addr_o        = w_buf_we ? bus.data_addr_i[AW-1:0] : '0;
  assign buf_wdata_o       = w_buf_we ? bus.data_wdata_i[EW-1:0] : '0;
  assign c_raddr_o         = w_c_rd ? bus.data_addr_i[AW-1:0] : '0;
  assign acc_start_o       = r_start;
  assign irq_o             = r_irq_en & ((r_state == ST_DONE) | (r_state == ST_ERR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_irq_en  <= 1'b0;
      r_acc_err <= 1'b0;
      r_start   <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_cycles  <= '0;
      r_timeout <= '0;
    end else begin
      r_rvalid <= w_req;
      r_rdata  <= w_rd ? w_rd_dat : '0;
      r_start  <= 1'b0;
      if (w_ctrl_wr) r_irq_en <= bus.data_wdata_i[CTRL_IRQ_EN];
      if (w_reg_wr && (w_reg_idx == REG_TIMEOUT)) r_timeout <= bus.data_wdata_i;
      if (w_clr_wr || w_stat_clr)             r_acc_err <= 1'b0;
      else if (w_run && (w_ab_wr || w_c_rd))  r_acc_err <= 1'b1;
      case (r_state)
        ST_RUN: begin
          r_cycles <= w_cyc_nxt;
          // Completion takes priority over a timeout landing in the same cycle.
          if (acc_done_i)
            r_state <= ST_DONE;
          else if ((r_timeout != '0) && (w_cyc_nxt == r_timeout))
            r_state <= ST_ERR;
        end
        default: begin
          if (w_start_wr) begin
            r_state  <= ST_RUN;
            r_cycles <= '0;
            r_start  <= 1'b1;
          end else if (w_clr_wr) begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_ctrl.sv
// Directed bench for acc_ctrl with scoreboarded bus responses and buffer writes.
// Inputs change 2 time units after a rising edge; monitor samples on the falling edge.
module tb_acc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       buf_we_o, buf_sel_o, acc_start_o, acc_done_i, irq_o;
  logic [9:0] buf_addr_o, c_raddr_o;
  logic [7:0] buf_wdata_o, c_rdata_i;

  acc_ctrl_if bus ();

  acc_ctrl #(.N_ELEM(1024), .EW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .buf_we_o    (buf_we_o),
    .buf_sel_o   (buf_sel_o),
    .buf_addr_o  (buf_addr_o),
    .buf_wdata_o (buf_wdata_o),
    .c_raddr_o   (c_raddr_o),
    .c_rdata_i   (c_rdata_i),
    .acc_start_o (acc_start_o),
    .acc_done_i  (acc_done_i),
    .irq_o       (irq_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] dat;
  } bus_exp_t;

  bus_exp_t    exp_q[$];
  logic [18:0] buf_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_start = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic outs_any();
    return |{bus.data_gnt_o, bus.data_rvalid_o, bus.data_rdata_o, buf_we_o, buf_sel_o,
             buf_addr_o, buf_wdata_o, c_raddr_o, acc_start_o, irq_o};
  endfunction

  // Monitor: pops expectations whenever the DUT presents a response or buffer strobe.
  always @(negedge clk) begin
    if (bus.data_rvalid_o) begin
      if (exp_q.size() == 0) chk("rvalid_unexpected", 32'd1, 32'd0);
      else begin
        bus_exp_t e;
        e = exp_q.pop_front();
        chk(e.name, bus.data_rdata_o, e.dat);
      end
    end
    if (buf_we_o) begin
      if (buf_q.size() == 0) chk("buf_we_unexpected", 32'd1, 32'd0);
      else chk("buf_write", {13'd0, buf_sel_o, buf_addr_o, buf_wdata_o}, {13'd0, buf_q.pop_front()});
    end
    if (acc_start_o) n_start++;
  end

  task automatic bus_op(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input string name);
    @(posedge clk); #2;
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = we;
    bus.data_addr_i  = addr;
    bus.data_wdata_i = wdata;
    exp_q.push_back('{name: name, dat: exp});
    #1;
    chk({name, "_gnt"}, {31'd0, bus.data_gnt_o}, 32'd1);
    if (!we && addr >= 12'd3072) chk({name, "_craddr"}, {22'd0, c_raddr_o}, {22'd0, addr[9:0]});
    @(posedge clk); #2;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_addr_i  = '0;
    bus.data_wdata_i = '0;
  endtask

  task automatic done_pulse();
    @(posedge clk); #2 acc_done_i = 1'b1;
    @(posedge clk); #2 acc_done_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    acc_done_i = 1'b0;
    c_rdata_i = 8'h00;
    bus.data_req_i = 1'b1;
    bus.data_we_i = 1'b1;
    bus.data_addr_i = 12'd1024;
    bus.data_wdata_i = 32'h55;
    #12;
    chk("reset_outputs_zero", {31'd0, outs_any()}, 32'd0);
    bus.data_req_i = 1'b0;
    bus.data_we_i = 1'b0;
    bus.data_addr_i = '0;
    bus.data_wdata_i = '0;
    #11 rst_n = 1'b1;

    bus_op(0, 12'd0, 0, 32'h0, "rst_ctrl");
    bus_op(0, 12'd1, 0, 32'h0, "rst_status");
    bus_op(0, 12'd2, 0, 32'h0, "rst_cycles");
    bus_op(0, 12'd3, 0, 32'h0, "rst_timeout");

    // Buffer writes in IDLE
    buf_q.push_back({1'b0, 10'd0, 8'h11});
    bus_op(1, 12'd1024, 32'h11, 32'h0, "wr_a0_resp");
    buf_q.push_back({1'b1, 10'd5, 8'h22});
    bus_op(1, 12'd2053, 32'hFF22, 32'h0, "wr_b5_resp");
    bus_op(0, 12'd100, 0, 32'h0, "rd_reserved");
    bus_op(1, 12'd100, 32'hFFFF, 32'h0, "wr_reserved_resp");

    // Normal run with done after 10 cycles
    bus_op(1, 12'd0, 32'h3, 32'h0, "start_irq_resp");
    chk("start_pulse_hi", {31'd0, acc_start_o}, 32'd1);
    repeat (9) @(posedge clk);
    #2 acc_done_i = 1'b1;
    @(posedge clk); #2 acc_done_i = 1'b0;
    chk("irq_in_done", {31'd0, irq_o}, 32'd1);
    bus_op(0, 12'd1, 0, 32'h2, "status_done");
    bus_op(0, 12'd2, 0, 32'd10, "cycles_done");
    bus_op(0, 12'd0, 0, 32'h2, "ctrl_readback");
    chk("start_count_1", n_start, 1);
    bus_op(1, 12'd0, 32'h4, 32'h0, "clr_resp");
    chk("irq_after_clr", {31'd0, irq_o}, 32'd0);
    bus_op(0, 12'd1, 0, 32'h0, "status_idle");
    done_pulse();
    bus_op(0, 12'd1, 0, 32'h0, "done_in_idle_ignored");

    // Timeout
    bus_op(1, 12'd3, 32'd5, 32'h0, "wr_timeout");
    bus_op(1, 12'd0, 32'h1, 32'h0, "start_tmo");
    repeat (8) @(posedge clk);
    #2 chk("irq_off_err", {31'd0, irq_o}, 32'd0);
    bus_op(0, 12'd1, 0, 32'h4, "status_err");
    bus_op(0, 12'd2, 0, 32'd5, "cycles_err");
    chk("start_count_2", n_start, 2);
    bus_op(1, 12'd0, 32'h4, 32'h0, "clr_err");
    bus_op(1, 12'd3, 32'd0, 32'h0, "wr_timeout0");

    // Access errors and START ignored during RUN
    bus_op(1, 12'd0, 32'h1, 32'h0, "start_acc");
    bus_op(1, 12'd1030, 32'h77, 32'h0, "wr_a_run_resp");
    c_rdata_i = 8'h5A;
    bus_op(0, 12'd3072, 0, 32'h0, "rd_c_run");
    bus_op(1, 12'd0, 32'h3, 32'h0, "start_in_run");
    bus_op(0, 12'd1, 0, 32'h9, "status_run_accerr");
    chk("start_count_3", n_start, 3);
    done_pulse();
    bus_op(0, 12'd1, 0, 32'hA, "status_done_accerr");
    chk("irq_done2", {31'd0, irq_o}, 32'd1);
    bus_op(1, 12'd1, 32'h8, 32'h0, "wr_status_clr");
    bus_op(0, 12'd1, 0, 32'h2, "status_accerr_cleared");

    // C readback in DONE
    c_rdata_i = 8'hAB;
    bus_op(0, 12'd3075, 0, 32'h000000AB, "rd_c3");
    bus_op(1, 12'd0, 32'h4, 32'h0, "clr_c");

    // START+CLR together, then reset mid-run with a read in flight
    bus_op(1, 12'd0, 32'h5, 32'h0, "start_clr");
    bus_op(0, 12'd1, 0, 32'h1, "status_start_wins");
    chk("start_count_4", n_start, 4);
    repeat (3) @(posedge clk);
    #2;
    bus.data_req_i = 1'b1;
    bus.data_addr_i = 12'd1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("midrun_reset_outputs_zero", {31'd0, outs_any()}, 32'd0);
    repeat (2) @(posedge clk);
    #2 bus.data_req_i = 1'b0;
    bus.data_addr_i = '0;
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    chk("no_start_after_reset", n_start, 4);
    bus_op(0, 12'd2, 0, 32'h0, "cycles_after_reset");
    bus_op(0, 12'd1, 0, 32'h0, "status_after_reset");

    repeat (3) @(posedge clk);
    chk("bus_q_drained", exp_q.size(), 0);
    chk("buf_q_drained", buf_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
